// File: rtl/mem_wb_skid_pkg.sv
// Shared definitions for the memory-to-writeback boundary: reset/write
// constants and the skid-buffer state encoding.
package mem_wb_skid_pkg;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic [31:0] ZeroWord     = 32'h0;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_TWO   = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_bundle_sanitize.sv
// Combinational write-enable cleanup for one bundle: drops $zero writes and
// lets the highest lane win when several lanes target the same register.
module wb_bundle_sanitize
  import mem_wb_skid_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int ADDR_W = 5
) (
  input  logic [LANES-1:0]        wreg,
  input  logic [LANES*ADDR_W-1:0] waddr,
  output logic [LANES-1:0]        wreg_clean
);

  always_comb begin
    wreg_clean = wreg;
    for (int i = 0; i < LANES; i++) begin
      if (waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(NOPRegAddr))
        wreg_clean[i] = WriteDisable;
      for (int j = i + 1; j < LANES; j++)
        if (wreg[j] && (waddr[j*ADDR_W +: ADDR_W] == waddr[i*ADDR_W +: ADDR_W]))
          wreg_clean[i] = WriteDisable;
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB boundary with a two-entry skid buffer so writeback can stall memory
// without losing a bundle. Enables are sanitised before they are stored.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [LANES-1:0]        mem_wReg,
  input  logic [LANES*ADDR_W-1:0] mem_wAddr,
  input  logic [LANES*DATA_W-1:0] mem_wData,
  input  logic                    mem_wHiLo,
  input  logic [DATA_W-1:0]       mem_hiData,
  input  logic [DATA_W-1:0]       mem_loData,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [LANES-1:0]        wb_wReg,
  output logic [LANES*ADDR_W-1:0] wb_wAddr,
  output logic [LANES*DATA_W-1:0] wb_wData,
  output logic                    wb_wHiLo,
  output logic [DATA_W-1:0]       wb_hiData,
  output logic [DATA_W-1:0]       wb_loData,
  output logic [1:0]              occupancy
);

  typedef struct packed {
    logic [LANES-1:0]        wreg;
    logic [LANES*ADDR_W-1:0] waddr;
    logic [LANES*DATA_W-1:0] wdata;
    logic                    whilo;
    logic [DATA_W-1:0]       hi;
    logic [DATA_W-1:0]       lo;
  } entry_t;

  wb_state_t        state, state_nxt;
  entry_t           main_q, skid_q, in_b;
  logic [LANES-1:0] wreg_clean;
  logic             accept, retire;
  logic             load_main_in, load_main_skid, load_skid, clr_main;

  wb_bundle_sanitize #(.LANES(LANES), .ADDR_W(ADDR_W)) u_sanitize (
    .wreg       (mem_wReg),
    .waddr      (mem_wAddr),
    .wreg_clean (wreg_clean)
  );

  assign in_b = '{wreg: wreg_clean, waddr: mem_wAddr, wdata: mem_wData,
                  whilo: mem_wHiLo, hi: mem_hiData, lo: mem_loData};

  assign wb_valid = (state != WB_EMPTY);
  assign accept   = mem_valid & mem_ready;
  assign retire   = wb_valid & wb_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    case (state)
      WB_EMPTY: if (accept) begin state_nxt = WB_ONE; load_main_in = 1'b1; end
      WB_ONE: begin
        if (accept && retire) load_main_in = 1'b1;
        else if (accept) begin state_nxt = WB_TWO; load_skid = 1'b1; end
        else if (retire) begin state_nxt = WB_EMPTY; clr_main = 1'b1; end
      end
      WB_TWO: if (retire) begin state_nxt = WB_ONE; load_main_skid = 1'b1; end
      default: begin state_nxt = WB_EMPTY; clr_main = 1'b1; end
    endcase
    // Flush drops everything, but a head retiring this cycle has already written.
    if (flush) begin
      state_nxt      = WB_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clr_main       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state     <= WB_EMPTY;
      mem_ready <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_nxt;
      mem_ready <= (state_nxt != WB_TWO);
      if (load_main_in)        main_q <= in_b;
      else if (load_main_skid) main_q <= skid_q;
      else if (clr_main) begin
        main_q.wreg  <= {LANES{WriteDisable}};
        main_q.whilo <= WriteDisable;
      end
      if (load_skid) skid_q <= in_b;
    end
  end

  assign wb_wReg   = main_q.wreg & {LANES{retire}};
  assign wb_wHiLo  = main_q.whilo & retire;
  assign wb_wAddr  = main_q.waddr;
  assign wb_wData  = main_q.wdata;
  assign wb_hiData = main_q.hi;
  assign wb_loData = main_q.lo;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      WB_ONE:  occupancy = 2'd1;
      WB_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Scoreboard bench for mem_wb_skid: a queue-based model of the buffer tracks
// accepted bundles and a monitor compares every cycle before the clock edge.
module tb_mem_wb_skid;
  localparam int DW = 32, AW = 5, L = 2;

  typedef struct {
    logic [L-1:0]         en;
    logic [L-1:0][AW-1:0] addr;
    logic [L-1:0][DW-1:0] data;
    logic                 hilo;
    logic [DW-1:0]        hi;
    logic [DW-1:0]        lo;
  } bundle_t;

  logic clk, rst, flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [L-1:0]    mem_wReg, wb_wReg;
  logic [L*AW-1:0] mem_wAddr, wb_wAddr;
  logic [L*DW-1:0] mem_wData, wb_wData;
  logic            mem_wHiLo, wb_wHiLo;
  logic [DW-1:0]   mem_hiData, mem_loData, wb_hiData, wb_loData;
  logic [1:0]      occupancy;

  mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wReg(mem_wReg), .mem_wAddr(mem_wAddr), .mem_wData(mem_wData),
    .mem_wHiLo(mem_wHiLo), .mem_hiData(mem_hiData), .mem_loData(mem_loData),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wReg(wb_wReg), .wb_wAddr(wb_wAddr), .wb_wData(wb_wData),
    .wb_wHiLo(wb_wHiLo), .wb_hiData(wb_hiData), .wb_loData(wb_loData),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      vectors = 0, miscompares = 0;
  bundle_t exp_q[$];
  bundle_t cur_exp;
  logic [DW-1:0] rf [32];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: among enabled lanes the last writer of an address wins,
  // and nothing ever writes r0.
  function automatic bundle_t ref_sanitize(input bundle_t b);
    bundle_t o = b;
    int last [32];
    for (int a = 0; a < 32; a++) last[a] = -1;
    for (int i = 0; i < L; i++) if (b.en[i]) last[b.addr[i]] = i;
    for (int i = 0; i < L; i++)
      o.en[i] = b.en[i] && (b.addr[i] != 0) && (last[b.addr[i]] == i);
    return o;
  endfunction

  function automatic bundle_t mk(input int a0, input int d0, input bit e0,
                                 input int a1, input int d1, input bit e1,
                                 input bit hl, input int hi, input int lo);
    bundle_t b;
    b.addr[0] = AW'(a0); b.data[0] = DW'(d0); b.en[0] = e0;
    b.addr[1] = AW'(a1); b.data[1] = DW'(d1); b.en[1] = e1;
    b.hilo = hl; b.hi = DW'(hi); b.lo = DW'(lo);
    return b;
  endfunction

  function automatic bundle_t rnd();
    return mk($urandom_range(0, 3), $urandom, 1'($urandom), $urandom_range(0, 3), $urandom,
              1'($urandom), 1'($urandom), $urandom, $urandom);
  endfunction

  task automatic step(input bit mv, input bundle_t b, input bit wr, input bit fl);
    @(negedge clk);
    mem_valid = mv; mem_wReg = b.en; mem_wAddr = b.addr; mem_wData = b.data;
    mem_wHiLo = b.hilo; mem_hiData = b.hi; mem_loData = b.lo;
    wb_ready = wr; flush = fl;
    cur_exp = ref_sanitize(b);
  endtask

  always @(posedge clk)
    if (!rst)
      for (int i = 0; i < L; i++)
        if (wb_wReg[i]) rf[wb_wAddr[i*AW +: AW]] <= wb_wData[i*DW +: DW];

  // Monitor: runs after inputs settle, before the next rising edge.
  initial begin
    int n;
    logic acc, ret;
    bundle_t h;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        n = exp_q.size();
        chk("mem_ready", mem_ready, n < 2);
        chk("occupancy", occupancy, n);
        chk("wb_valid", wb_valid, n > 0);
        ret = (n > 0) && wb_ready;
        acc = mem_valid && (n < 2);
        if (n > 0) begin
          h = exp_q[0];
          chk("wb_wReg", wb_wReg, ret ? h.en : 2'b00);
          chk("wb_wHiLo", wb_wHiLo, ret ? h.hilo : 1'b0);
          chk("wb_wAddr", wb_wAddr, h.addr);
          chk("wb_wData", wb_wData, h.data);
          chk("wb_hilo_data", {wb_hiData, wb_loData}, {h.hi, h.lo});
          if (ret) void'(exp_q.pop_front());
        end else begin
          chk("idle_enables", {wb_wReg, wb_wHiLo}, 0);
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(cur_exp);
      end
    end
  end

  initial begin
    bundle_t z, a, b, c;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; flush = 0; mem_valid = 0; wb_ready = 0;
    mem_wReg = '0; mem_wAddr = '0; mem_wData = '0; mem_wHiLo = 0; mem_hiData = '0; mem_loData = '0;
    #3;
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_enables", {wb_wReg, wb_wHiLo}, 0);
    chk("rst_addr_data", {wb_wAddr, wb_wData, wb_hiData, wb_loData}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Streaming
    step(1, mk(3, 'h11, 1, 4, 'h22, 1, 0, 0, 0), 1, 0);
    step(1, mk(5, 'h33, 1, 6, 'h44, 1, 0, 0, 0), 1, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);

    // Back-pressure: A, B taken, C held until space appears
    a = mk(1, 'hA1, 1, 2, 'hA2, 1, 0, 0, 0);
    b = mk(1, 'hB1, 1, 2, 'hB2, 0, 1, 'hB, 'hB);
    c = mk(9, 'hC1, 0, 10, 'hC2, 1, 0, 0, 0);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(1, c, 0, 0);
    step(1, c, 0, 0);
    step(1, c, 1, 0);
    step(1, c, 1, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);

    // Sanitising
    step(1, mk(0, 'hDEAD, 1, 0, 'hBEEF, 1, 0, 0, 0), 1, 0);
    step(1, mk(7, 'h1, 1, 7, 'h2, 1, 0, 0, 0), 1, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);
    chk("rf_r7", rf[7], 32'h2);

    // Flush in TWO with retire, then flush against an accept while EMPTY
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(0, z, 1, 1);
    step(1, c, 0, 1);
    step(0, z, 1, 0);

    // HI/LO held three cycles, then released
    step(1, mk(0, 0, 0, 0, 0, 0, 1, 'hAAAA0000, 'h0000BBBB), 0, 0);
    step(0, z, 0, 0);
    step(0, z, 0, 0);
    step(0, z, 0, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

    // Asynchronous reset while in TWO
    step(0, z, 0, 1);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(0, z, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_wb_valid", wb_valid, 1'b0);
    chk("arst_mem_ready", mem_ready, 1'b1);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_enables", {wb_wReg, wb_wHiLo}, 0);
    chk("arst_addr_data", {wb_wAddr, wb_wData, wb_hiData, wb_loData}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, c, 1, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);
    @(negedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised memory-to-writeback pipeline boundary with a valid/ready handshake and a two-entry skid buffer. It carries a write-back bundle (`LANES` GPR write ports plus one HI/LO write) from the memory stage to the register file and HI/LO unit. It replaces the plain always-load boundary register, so writeback can back-pressure memory without losing a bundle. It adds a flush input, $zero write suppression and same-bundle write-collision resolution.

## Interface
Parameters:
- `DATA_W`, 32: GPR and HI/LO data width.
- `ADDR_W`, 5: GPR address width.
- `LANES`, 1: GPR write ports per bundle (1..4).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `flush`  in  1  synchronous discard of all buffered bundles.
- `mem_valid`  in  1  upstream bundle present.
- `mem_ready`  out  1  buffer can accept; registered.
- `mem_wReg`  in  LANES  per-lane GPR write enable.
- `mem_wAddr`  in  LANES*ADDR_W  per-lane GPR address; lane i occupies bits [i*ADDR_W +: ADDR_W].
- `mem_wData`  in  LANES*DATA_W  per-lane GPR data.
- `mem_wHiLo`  in  1  HI/LO write enable.
- `mem_hiData`, `mem_loData`  in  DATA_W each  HI/LO data.
- `wb_valid`  out  1  head bundle present.
- `wb_ready`  in  1  writeback consumes the head bundle this cycle.
- `wb_wReg`  out  LANES  effective GPR write enable; already gated by the handshake.
- `wb_wAddr`, `wb_wData`  out  same widths as inputs  head bundle GPR address and data.
- `wb_wHiLo`  out  1  effective HI/LO write enable; already gated by the handshake.
- `wb_hiData`, `wb_loData`  out  DATA_W each  head bundle HI/LO data.
- `occupancy`  out  2  bundles held: 0, 1 or 2.

## Operation
- Handshakes:
  - Accept occurs when `mem_valid & mem_ready`.
  - Retire occurs when `wb_valid & wb_ready`.
- Storage:
  - Two entries: MAIN (head) and SKID.
  - State is EMPTY, ONE (MAIN full) or TWO (MAIN and SKID full).
- State transitions when flush is not asserted:
  - EMPTY + accept -> ONE; the bundle loads MAIN.
  - ONE + accept + retire -> ONE; MAIN is replaced by the new bundle.
  - ONE + accept only -> TWO; the bundle loads SKID.
  - ONE + retire only -> EMPTY.
  - TWO + retire -> ONE; SKID moves to MAIN. No accept is possible in TWO.
- `mem_ready` is 1 in EMPTY and ONE, and 0 in TWO. It is a flop output.
- Flush:
  - Next state is EMPTY.
  - Flush wins over a simultaneous accept; that accepted bundle is dropped.
  - A simultaneous retire still completes; the current head writes this cycle.
- Sanitising is applied on entry, so stored enables are already clean:
  - Lane i's write enable is forced to 0 when `mem_wAddr` lane i equals `NOPRegAddr` (0).
  - For i<j with the same address and both enabled, lane i is cleared; the higher lane wins.
- Output gating:
  - `wb_wReg[i]` = stored enable & `wb_valid` & `wb_ready`. `wb_wHiLo` is gated the same way.
  - Data and address outputs show MAIN unconditionally.
  - Stored enables are 0 whenever MAIN is empty.
- Reset values:
  - `mem_ready`=1 and `wb_valid`=0.
  - All enables are `WriteDisable`.
  - Addresses are `NOPRegAddr`; all data outputs are `ZeroWord`.
  - `occupancy`=0.
- Reset mid-operation discards both entries without any write-back.

## Timing
- Latency: a bundle accepted at edge N appears on `wb_*` with `wb_valid`=1 after edge N, provided the buffer was EMPTY or the head retires at edge N.
- Throughput: one bundle per cycle while `wb_ready` is held at 1.
- The `wb_ready`-to-`mem_ready` path is registered: no combinational path from `wb_ready` to `mem_ready`.
- The only combinational paths from inputs to outputs are `wb_ready` -> `wb_wReg` and `wb_ready` -> `wb_wHiLo`.
- `occupancy` updates on the same edge as the state.

## Structure
- Shared defines file gains:
  - `WB_EMPTY`, `WB_ONE` and `WB_TWO` state encodings.
  - Existing `RstEnable`, `WriteDisable`, `NOPRegAddr` and `ZeroWord` are reused.
- Sub-module `wb_bundle_sanitize`: combinational $zero and collision masking, parametrised by `LANES` and `ADDR_W`.
- The top level holds the state machine and both entry registers.

## Test plan
- Streaming:
  - Stimulus: LANES=2, `wb_ready`=1; send bundles {r3<-0x11, r4<-0x22} and {r5<-0x33, r6<-0x44} back-to-back.
  - Required: each bundle appears one cycle after its accept; `mem_ready` stays 1; `occupancy` stays 1.
- Back-pressure:
  - Stimulus: `wb_ready`=0 and three bundles A, B, C offered.
  - Required: A and B are accepted; `mem_ready`=0 and `occupancy`=2; C is held upstream.
  - Then raise `wb_ready`: output order is A, B, C with none lost or duplicated.
- Sanitising:
  - Stimulus: lane0 {r0<-0xDEAD, en=1}, lane1 {r0, en=1}.
  - Required: both `wb_wReg` bits are 0.
  - Stimulus: lane0 {r7<-0x1} and lane1 {r7<-0x2}, both enabled.
  - Required: only lane1 is enabled; the register file sees r7=0x2.
- Flush:
  - Stimulus: in TWO, assert `flush` together with `wb_ready`=1.
  - Required: the head writes in that cycle; the next cycle has `wb_valid`=0 and `occupancy`=0.
  - Stimulus: `flush` together with an accept while EMPTY.
  - Required: the bundle is dropped.
- HI/LO:
  - Stimulus: bundle with `mem_wHiLo`=1, hi=0xAAAA0000, lo=0x0000BBBB, held with `wb_ready`=0 for 3 cycles.
  - Required: `wb_wHiLo`=0 while held; `wb_wHiLo`=1 for exactly one cycle after `wb_ready` rises.
- Asynchronous reset:
  - Stimulus: assert `rst` mid-cycle while in TWO.
  - Required: before the next clock edge, `wb_valid`=0, `mem_ready`=1 and `occupancy`=0, and all outputs hold their reset values.
